isa_dma_target: RTL and testbench

- 8-bit ISA-side target (bus responder) for the XT chipset bus.
- Handles both access types from the bus master: CPU programmed I/O (PIO) to a small register window, and single-mode DMA transfers on one channel.
- On the bus side it responds to io_read_n/io_write_n, drives the DMA request line, accepts the DMA acknowledge and terminal count, and stretches cycles via io_channel_ready.
- On the local side it exposes two byte FIFOs with valid/ready handshakes, so peripheral logic can stream data to and from host memory.

---
 rtl/isa_dma_target.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_isa_dma_target.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_dma_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : isa_dma_target                                               |
// | Description : 8-bit XT/ISA bus target. Serves CPU programmed I/O to a      |
// |               4-byte register window and single-mode DMA on one channel,  |
// |               bridging both to local tx (device->host) and rx             |
// |               (host->device) byte FIFOs with valid/ready handshakes.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module isa_dma_target #(
  parameter logic [9:0] BASE_PORT   = 10'h300,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_out,
  output logic        data_out_enable,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        address_enable_n,
  output logic        dma_request,
  input  logic        dma_acknowledge_n,
  input  logic        terminal_count_n,
  output logic        io_channel_ready,
  output logic        interrupt_request,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  // Upper address bits are outside the 10-bit I/O decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[19:10];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic          ior_q, iow_q;
  logic          live_q;
  logic          rd_path_q;
  logic          wr_push_q, wr_ctrl_q, wr_stat_q;
  logic [7:0]    wdata_q;
  logic [2:0]    ctrl_q;
  logic          tc_seen_q, rx_overflow_q, tx_underrun_q;
  logic [WW-1:0] wait_q;
  state_t        state_q;
  logic          dreq_q;
  logic          tc_pend_q;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_count_q;
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_count_q;

  // ---------------------------------------------------------------------------
  // Decode and strobe edges (raw strobe against its registered copy)
  // ---------------------------------------------------------------------------
  logic sel_pio, sel_dma, sel_any;
  logic rd_low, rd_fall, rd_rise, wr_fall, wr_rise;
  logic rd_path_now;

  assign sel_pio     = address_enable_n && (address[9:2] == BASE_PORT[9:2]);
  assign sel_dma     = !dma_acknowledge_n && !address_enable_n;
  assign sel_any     = sel_pio || sel_dma;
  assign rd_low      = !io_read_n;
  assign rd_fall     = ior_q && !io_read_n;
  assign rd_rise     = !ior_q && io_read_n;
  // A write overlapping a read is ignored: the read wins.
  assign wr_fall     = iow_q && !io_write_n && io_read_n;
  assign wr_rise     = !iow_q && io_write_n;
  assign rd_path_now = sel_dma || (sel_pio && address[1:0] == 2'd0);

  // ---------------------------------------------------------------------------
  // FIFO status and transfer events
  // ---------------------------------------------------------------------------
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic underrun_set, overflow_set, ctrl_wr, stat_wr, ack_end, tc_hit;
  logic dreq_cond;

  assign tx_empty     = (tx_count_q == '0);
  assign tx_full      = (tx_count_q == CW'(FIFO_DEPTH));
  assign rx_empty     = (rx_count_q == '0);
  assign rx_full      = (rx_count_q == CW'(FIFO_DEPTH));

  assign tx_push      = tx_valid && !tx_full;
  assign tx_pop       = rd_rise && rd_path_q && !tx_empty;
  assign underrun_set = rd_rise && rd_path_q && tx_empty;
  assign rx_push      = wr_rise && wr_push_q && !rx_full;
  assign overflow_set = wr_rise && wr_push_q && rx_full;
  assign rx_pop       = rx_ready && !rx_empty;
  assign ctrl_wr      = wr_rise && wr_ctrl_q;
  assign stat_wr      = wr_rise && wr_stat_q;

  assign ack_end      = (state_q == ST_ACK) && (rd_rise || wr_rise);
  assign tc_hit       = ack_end && (tc_pend_q || !terminal_count_n);
  assign dreq_cond    = !tc_seen_q && (ctrl_q[1] ? !tx_empty : !rx_full);

  assign tx_ready          = !tx_full;
  assign rx_valid          = !rx_empty;
  assign rx_data           = rx_mem_q[rx_rptr_q];
  assign dma_request       = dreq_q;
  assign io_channel_ready  = (wait_q == '0);
  assign interrupt_request = ctrl_q[2] && tc_seen_q;

  // ---------------------------------------------------------------------------
  // Read data: combinational while a qualified read strobe is low
  // ---------------------------------------------------------------------------
  logic [7:0] rd_mux;
  logic [7:0] tx_head;
  logic [7:0] status;

  assign tx_head = tx_empty ? 8'hFF : tx_mem_q[tx_rptr_q];
  assign status  = {3'b000, tx_underrun_q, rx_overflow_q, tc_seen_q, rx_full, tx_empty};

  // Select the byte presented for the current read access.
  always_comb begin
    rd_mux = 8'hFF;
    if (sel_dma) begin
      rd_mux = tx_head;
    end else begin
      case (address[1:0])
        2'd0:    rd_mux = tx_head;
        2'd1:    rd_mux = {5'b00000, ctrl_q};
        2'd2:    rd_mux = status;
        default: rd_mux = 8'hFF;
      endcase
    end
  end

  // live_q drops asynchronously with reset so the bus is released at once.
  assign data_out_enable = live_q && rd_low && sel_any;
  assign data_out        = data_out_enable ? rd_mux : 8'hFF;

  // Strobe registers, bus-release gate and per-access capture while strobes are low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      live_q    <= 1'b0;
      rd_path_q <= 1'b0;
      wr_push_q <= 1'b0;
      wr_ctrl_q <= 1'b0;
      wr_stat_q <= 1'b0;
      wdata_q   <= 8'h00;
    end else begin
      ior_q  <= io_read_n;
      iow_q  <= io_write_n;
      live_q <= 1'b1;
      if (rd_low) begin
        rd_path_q <= rd_path_now;
      end
      if (!io_write_n) begin
        wr_push_q <= io_read_n && rd_path_now;
        wr_ctrl_q <= io_read_n && sel_pio && (address[1:0] == 2'd1);
        wr_stat_q <= io_read_n && sel_pio && (address[1:0] == 2'd2);
        wdata_q   <= data_bus_in;
      end
    end
  end

  // Control register and sticky status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q        <= 3'b000;
      tc_seen_q     <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= wdata_q[2:0];
      end
      if (stat_wr) begin
        if (wdata_q[2]) tc_seen_q     <= 1'b0;
        if (wdata_q[3]) rx_overflow_q <= 1'b0;
        if (wdata_q[4]) tx_underrun_q <= 1'b0;
      end
      if (overflow_set) rx_overflow_q <= 1'b1;
      if (underrun_set) tx_underrun_q <= 1'b1;
      // Terminal count ends the block: stop further requests.
      if (tc_hit) begin
        tc_seen_q <= 1'b1;
        ctrl_q[0] <= 1'b0;
      end
    end
  end

  // Wait-state counter: loaded on a qualified strobe fall, cut short on release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if ((rd_fall || wr_fall) && sel_any) begin
      wait_q <= WW'(WAIT_CYCLES);
    end else if (io_read_n && io_write_n) begin
      wait_q <= '0;
    end else if (wait_q != '0) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  // DREQ handshake: IDLE -> REQ -> ACK -> RECOVER, gated by enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dreq_q    <= 1'b0;
      tc_pend_q <= 1'b0;
    end else if (!ctrl_q[0]) begin
      state_q   <= ST_IDLE;
      dreq_q    <= 1'b0;
      tc_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tc_pend_q <= 1'b0;
          if (dreq_cond) begin
            state_q <= ST_REQ;
            dreq_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if ((rd_fall || wr_fall) && sel_dma) begin
            state_q <= ST_ACK;
            dreq_q  <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!terminal_count_n) tc_pend_q <= 1'b1;
          if (rd_rise || wr_rise) state_q <= ST_RECOVER;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // tx FIFO pointers and occupancy (local push, bus pop).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - 1'b1;
    end
  end

  // tx FIFO storage.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
  end

  // rx FIFO pointers and occupancy (bus push, local pop).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - 1'b1;
    end
  end

  // rx FIFO storage.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_isa_dma_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_isa_dma_target                                            |
// | Description : Directed bench for isa_dma_target with a read-data          |
// |               scoreboard and a DREQ low-gap monitor.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_isa_dma_target;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  data_bus_in;
  logic [7:0]  data_out;
  logic        data_out_enable;
  logic        io_read_n, io_write_n, address_enable_n;
  logic        dma_request, dma_acknowledge_n, terminal_count_n;
  logic        io_channel_ready, interrupt_request;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  bit rd_seen  = 1'b0;
  bit hi_seen  = 1'b0;
  int low_run  = 0;
  int lows;
  bit got;

  isa_dma_target #(
    .BASE_PORT(10'h300), .FIFO_DEPTH(16), .WAIT_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .data_bus_in(data_bus_in),
    .data_out(data_out), .data_out_enable(data_out_enable),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .address_enable_n(address_enable_n), .dma_request(dma_request),
    .dma_acknowledge_n(dma_acknowledge_n), .terminal_count_n(terminal_count_n),
    .io_channel_ready(io_channel_ready), .interrupt_request(interrupt_request),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: one comparison per bus read, when the DUT drives the bus.
  always @(negedge clock) begin
    if (data_out_enable && !rd_seen) begin
      rd_seen = 1'b1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data actual=%0h required=none", data_out);
      end else begin
        check("rd_data", data_out, exp_q.pop_front());
      end
    end else if (!data_out_enable) begin
      rd_seen = 1'b0;
    end
  end

  // DREQ must stay low at least 2 clocks between consecutive requests.
  always @(negedge clock) begin
    if (reset) begin
      hi_seen = 1'b0;
      low_run = 0;
    end else if (dma_request) begin
      if (hi_seen && low_run > 0) check("dreq_gap_ge2", (low_run >= 2), 1);
      hi_seen = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic pio_write(logic [19:0] a, logic [7:0] d);
    address = a; address_enable_n = 1'b1; dma_acknowledge_n = 1'b1;
    data_bus_in = d; io_write_n = 1'b0;
    tick(4);
    io_write_n = 1'b1;
    tick(2);
  endtask

  task automatic pio_read(logic [19:0] a, logic [7:0] exp);
    address = a; address_enable_n = 1'b1; dma_acknowledge_n = 1'b1;
    exp_q.push_back(exp);
    io_read_n = 1'b0;
    tick(4);
    io_read_n = 1'b1;
    tick(2);
  endtask

  task automatic wait_dreq(string name);
    int n = 0;
    while (!dma_request && n < 20) begin
      tick(1);
      n++;
    end
    check(name, dma_request, 1);
  endtask

  task automatic dma_read(logic [7:0] exp, bit tc);
    wait_dreq("dreq_before_ior");
    address = 20'h00000; address_enable_n = 1'b0; dma_acknowledge_n = 1'b0;
    terminal_count_n = !tc;
    exp_q.push_back(exp);
    io_read_n = 1'b0;
    tick(4);
    io_read_n = 1'b1;
    tick(1);
    dma_acknowledge_n = 1'b1; address_enable_n = 1'b1; terminal_count_n = 1'b1;
    tick(1);
  endtask

  task automatic dma_write(logic [7:0] d);
    wait_dreq("dreq_before_iow");
    address = 20'h00000; address_enable_n = 1'b0; dma_acknowledge_n = 1'b0;
    data_bus_in = d; io_write_n = 1'b0;
    tick(4);
    io_write_n = 1'b1;
    tick(1);
    dma_acknowledge_n = 1'b1; address_enable_n = 1'b1;
    tick(1);
  endtask

  task automatic push_tx(logic [7:0] d);
    tx_valid = 1'b1; tx_data = d;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; address = 20'h0; data_bus_in = 8'h00;
    io_read_n = 1'b1; io_write_n = 1'b1; address_enable_n = 1'b1;
    dma_acknowledge_n = 1'b1; terminal_count_n = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    #2 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_dreq", dma_request, 0);
    check("rst_ready", io_channel_ready, 1);
    check("rst_dout", data_out, 8'hFF);
    check("rst_doe", data_out_enable, 0);
    check("rst_irq", interrupt_request, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    pio_read(20'h00302, 8'h01);
    pio_read(20'h00301, 8'h00);

    // PIO loopback and register window
    pio_write(20'h00301, 8'h06);
    pio_write(20'h00300, 8'hA5);
    check("pio_rx_valid", rx_valid, 1);
    check("pio_rx_data", rx_data, 8'hA5);
    pio_read(20'h00302, 8'h01);
    pio_read(20'h00301, 8'h06);
    pio_read(20'h00303, 8'hFF);
    pop_rx();
    check("pio_rx_drained", rx_valid, 0);

    // Wait states on an empty-tx data read
    address = 20'h00300; address_enable_n = 1'b1;
    check("ws_ready_idle", io_channel_ready, 1);
    exp_q.push_back(8'hFF);
    io_read_n = 1'b0;
    lows = 0;
    repeat (6) begin
      @(negedge clock);
      if (!io_channel_ready) lows++;
    end
    @(posedge clock); #1;
    io_read_n = 1'b1;
    tick(2);
    check("ws_low_clocks", lows, 2);
    pio_read(20'h00302, 8'h11);
    pio_write(20'h00302, 8'h10);
    pio_read(20'h00302, 8'h01);

    // DMA device-to-memory with terminal count on the third byte
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    pio_write(20'h00301, 8'h07);
    check("d2m_dreq_on", dma_request, 1);
    dma_read(8'h11, 1'b0);
    dma_read(8'h22, 1'b0);
    dma_read(8'h33, 1'b1);
    tick(4);
    check("d2m_irq", interrupt_request, 1);
    check("d2m_dreq_off", dma_request, 0);
    pio_read(20'h00301, 8'h06);
    pio_read(20'h00302, 8'h05);
    check("d2m_dreq_stays_off", dma_request, 0);

    // DMA memory-to-device with rx full
    pio_write(20'h00302, 8'h04);
    check("m2d_irq_clear", interrupt_request, 0);
    for (int i = 0; i < 16; i++) pio_write(20'h00300, 8'h40 + 8'(i));
    pio_read(20'h00302, 8'h03);
    pio_write(20'h00301, 8'h01);
    tick(3);
    check("m2d_dreq_full", dma_request, 0);
    pio_write(20'h00300, 8'hEE);
    pio_read(20'h00302, 8'h0B);
    pio_write(20'h00302, 8'h08);
    pio_read(20'h00302, 8'h03);
    check("m2d_head", rx_data, 8'h40);
    pop_rx();
    got = 1'b0;
    repeat (2) begin
      tick(1);
      if (dma_request) got = 1'b1;
    end
    check("m2d_dreq_after_pop", got, 1);
    dma_write(8'h5A);
    pio_write(20'h00301, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check("m2d_drain", rx_data, (i < 15) ? (8'h41 + 8'(i)) : 8'h5A);
      pop_rx();
    end
    check("m2d_rx_empty", rx_valid, 0);

    // Local push coinciding with the bus pop
    push_tx(8'h77);
    address = 20'h00300; address_enable_n = 1'b1;
    exp_q.push_back(8'h77);
    io_read_n = 1'b0;
    tick(4);
    io_read_n = 1'b1; tx_valid = 1'b1; tx_data = 8'h88;
    tick(1);
    tx_valid = 1'b0;
    tick(1);
    pio_read(20'h00302, 8'h00);
    pio_read(20'h00300, 8'h88);
    pio_read(20'h00302, 8'h01);

    // Asynchronous reset in the middle of an acknowledged DMA read
    push_tx(8'h99);
    pio_write(20'h00301, 8'h03);
    wait_dreq("rst_dreq_before");
    address = 20'h00000; address_enable_n = 1'b0; dma_acknowledge_n = 1'b0;
    exp_q.push_back(8'h99);
    io_read_n = 1'b0;
    tick(2);
    check("mid_ready_low", io_channel_ready, 0);
    check("mid_doe", data_out_enable, 1);
    reset = 1'b1;
    #1;
    check("ar_dreq", dma_request, 0);
    check("ar_doe", data_out_enable, 0);
    check("ar_ready", io_channel_ready, 1);
    check("ar_dout", data_out, 8'hFF);
    check("ar_rx_valid", rx_valid, 0);
    io_read_n = 1'b1; dma_acknowledge_n = 1'b1; address_enable_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    pio_read(20'h00302, 8'h01);
    pio_read(20'h00301, 8'h00);
    check("ar_dreq_after", dma_request, 0);

    tick(2);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
